// File: rtl/rand_verif_pkg.sv
// ---------------------------------------------------------------------------
// rand_verif_pkg
//   Shared types and constants for the synthesizable random-stimulus blocks
//   (rand_lfsr, rand_stream_throttle and future siblings).
//
//   Contents:
//     throttle_state_e : FSM state of rand_stream_throttle (OPEN / WAIT)
//     LfsrPoly         : default Galois feedback polynomial for 32-bit LFSRs
//     WaitCntWidth     : width of the throttle gap down-counter
//     satInc32         : saturating 32-bit increment used by statistic counters
// ---------------------------------------------------------------------------
package rand_verif_pkg;

  typedef enum logic {
    THR_OPEN,
    THR_WAIT
  } throttle_state_e;

  localparam logic [31:0] LfsrPoly = 32'h8020_0003;

  localparam int unsigned WaitCntWidth = 16;

  // Statistic counters stick at all-ones instead of wrapping, so a long run
  // never reports a misleadingly small count.
  function automatic logic [31:0] satInc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage : rand_verif_pkg

// File: rtl/rand_lfsr.sv
// ---------------------------------------------------------------------------
// rand_lfsr
//   Free-running Galois LFSR, reusable by any block that needs a cheap
//   pseudo-random source on silicon or FPGA where $urandom does not exist.
//   The register shifts right every clock while out of reset; when the bit
//   shifted out is 1 the polynomial is XORed into the shifted value.
//
//   Parameters:
//     Width : register width in bits (>= 2)
//     Poly  : feedback polynomial (Galois form, right-shifting)
//     Seed  : reset value, must be non-zero or the register locks at zero
//
//   Ports:
//     clk_i   in   1      clock, posedge
//     rst_ni  in   1      asynchronous active-low reset (loads Seed)
//     state_o out  Width  current LFSR contents
// ---------------------------------------------------------------------------
module rand_lfsr
  import rand_verif_pkg::*;
#(
  parameter int unsigned       Width = 32,
  parameter logic [Width-1:0]  Poly  = Width'(LfsrPoly),
  parameter logic [Width-1:0]  Seed  = Width'(32'hDEADBEEF)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [Width-1:0] state_o
);

  if (Width < 2) begin : gBadWidth
    $error("rand_lfsr: Width must be at least 2");
  end

  // An all-zero state is a fixed point of any XOR-feedback LFSR.
  if (Seed == '0) begin : gZeroSeed
    $error("rand_lfsr: Seed must be non-zero");
  end

  logic [Width-1:0] r_state;
  logic [Width-1:0] w_next;

  always_comb begin
    w_next = {1'b0, r_state[Width-1:1]};
    if (r_state[0]) begin
      w_next = w_next ^ Poly;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= Seed;
    end else begin
      r_state <= w_next;
    end
  end

  assign state_o = r_state;

endmodule : rand_lfsr

// File: rtl/rand_stream_throttle.sv
// ---------------------------------------------------------------------------
// rand_stream_throttle
//   valid/ready pass-through that closes the stream for a pseudo-random
//   number of cycles after every transfer. Each gap w is drawn from
//   [MinWait, MaxWait] using the low 16 bits of a free-running LFSR, so the
//   same random back-pressure used on the simulation bench also runs on
//   emulation/FPGA. Payload is never buffered: data_o is data_i.
//
//   Parameters:
//     DataWidth : payload width in bits
//     MinWait   : minimum closed cycles after a transfer
//     MaxWait   : maximum closed cycles after a transfer (MinWait..65535)
//     Seed      : LFSR reset value, non-zero
//
//   Ports:
//     clk_i       in   1          clock, posedge
//     rst_ni      in   1          asynchronous active-low reset
//     en_i        in   1          1: throttle active, 0: pure pass-through
//     valid_i     in   1          upstream valid
//     ready_o     out  1          upstream ready
//     data_i      in   DataWidth  upstream payload
//     valid_o     out  1          downstream valid
//     ready_i     in   1          downstream ready
//     data_o      out  DataWidth  downstream payload
//     stalling_o  out  1          high while closed (WAIT and en_i=1)
//
//   Optional build macro RAND_STREAM_THROTTLE_STATS_EN adds:
//     xfer_cnt_o  out  32         saturating count of throttled transfers
//     stall_cnt_o out  32         saturating count of stalling cycles
// ---------------------------------------------------------------------------
module rand_stream_throttle
  import rand_verif_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MinWait   = 0,
  parameter int unsigned MaxWait   = 8,
  parameter logic [31:0] Seed      = 32'hDEADBEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 stalling_o
`ifdef RAND_STREAM_THROTTLE_STATS_EN
  ,
  output logic [31:0]          xfer_cnt_o,
  output logic [31:0]          stall_cnt_o
`endif
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  if (MinWait > MaxWait) begin : gBadRange
    $error("rand_stream_throttle: MinWait must not exceed MaxWait");
  end

  if (MaxWait >= (1 << WaitCntWidth)) begin : gBadMax
    $error("rand_stream_throttle: MaxWait must fit in the 16-bit gap counter");
  end

  if (Seed == 32'd0) begin : gBadSeed
    $error("rand_stream_throttle: Seed must be non-zero");
  end

  // Number of distinct gap values; 17 bits because a full 0..65535 range
  // has 65536 entries.
  localparam logic [WaitCntWidth:0] WaitRange = (WaitCntWidth + 1)'(MaxWait - MinWait + 1);

  // -------------------------------------------------------------------------
  // Random source
  // -------------------------------------------------------------------------
  logic [31:0] w_lfsr;

  rand_lfsr #(
    .Width (32),
    .Poly  (LfsrPoly),
    .Seed  (Seed)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .state_o (w_lfsr)
  );

  // Only the low half of the LFSR feeds the gap draw.
  logic w_unusedLfsrHigh;
  assign w_unusedLfsrHigh = ^w_lfsr[31:16];

  // -------------------------------------------------------------------------
  // Gap draw: w = MinWait + (lfsr[15:0] mod range). With MinWait == MaxWait
  // the range is 1 and the modulo folds away to a constant.
  // -------------------------------------------------------------------------
  logic [WaitCntWidth:0]   w_mod;
  logic [WaitCntWidth-1:0] w_wait;

  assign w_mod  = {1'b0, w_lfsr[15:0]} % WaitRange;
  assign w_wait = WaitCntWidth'((WaitCntWidth + 1)'(MinWait) + w_mod);

  // -------------------------------------------------------------------------
  // Throttle FSM
  // -------------------------------------------------------------------------
  throttle_state_e         r_state;
  logic [WaitCntWidth-1:0] r_cnt;

  logic w_closed;
  logic w_xfer;

  // Closing is gated by en_i combinationally so that dropping en_i opens the
  // stream in the very same cycle, even in the middle of a gap.
  assign w_closed = (r_state == THR_WAIT) && en_i;
  assign w_xfer   = valid_i && ready_i && en_i && (r_state == THR_OPEN);

  // WAIT is only ever entered straight after a handshake, so valid_o can
  // never be withdrawn while a beat is still pending downstream.
  // cnt holds the number of closed cycles still to go including the current
  // one; reaching 1 means this is the last closed cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= THR_OPEN;
      r_cnt   <= '0;
    end else if (!en_i) begin
      r_state <= THR_OPEN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        THR_OPEN: begin
          if (w_xfer && (w_wait != '0)) begin
            r_state <= THR_WAIT;
            r_cnt   <= w_wait;
          end
        end
        THR_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == WaitCntWidth'(1)) begin
            r_state <= THR_OPEN;
          end
        end
        default: begin
          r_state <= THR_OPEN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Stream outputs: zero latency, no storage
  // -------------------------------------------------------------------------
  assign valid_o    = valid_i && !w_closed;
  assign ready_o    = ready_i && !w_closed;
  assign data_o     = data_i;
  assign stalling_o = w_closed;

`ifdef RAND_STREAM_THROTTLE_STATS_EN
  // -------------------------------------------------------------------------
  // Optional statistics
  // -------------------------------------------------------------------------
  logic [31:0] r_xferCnt;
  logic [31:0] r_stallCnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_xferCnt  <= '0;
      r_stallCnt <= '0;
    end else begin
      if (w_xfer) begin
        r_xferCnt <= satInc32(r_xferCnt);
      end
      if (w_closed) begin
        r_stallCnt <= satInc32(r_stallCnt);
      end
    end
  end

  assign xfer_cnt_o  = r_xferCnt;
  assign stall_cnt_o = r_stallCnt;
`endif

endmodule : rand_stream_throttle

// File: tb/tb_rand_stream_throttle.sv
// ---------------------------------------------------------------------------
// tb_rand_stream_throttle
//   Four throttle instances run side by side on one clock and reset:
//     0: MinWait=MaxWait=3, source/sink always active
//     1: MinWait=MaxWait=0, source/sink always active
//     2: MinWait=2, MaxWait=5, source/sink always active (random gaps)
//     3: MinWait=MaxWait=4, random valid/ready, en_i dropped early in gaps
//   Fixed-gap instances are checked cycle by cycle against a gap model;
//   instance 2 is checked for gap range/coverage and for gap-sequence
//   repeatability across a mid-gap reset. Every instance has a data
//   scoreboard. Build with RAND_STREAM_THROTTLE_STATS_EN to also check the
//   statistic counters.
// ---------------------------------------------------------------------------
module tb_rand_stream_throttle;

  localparam int NumDut = 4;
  localparam int MinW [NumDut] = '{3, 0, 2, 4};
  localparam int MaxW [NumDut] = '{3, 0, 5, 4};
  localparam int NumGapRec = 16;
  localparam int TargetXfers = 10000;

  logic clk;
  logic rst_n;

  logic        enI    [NumDut];
  logic        validI [NumDut];
  logic        readyI [NumDut];
  logic        validO [NumDut];
  logic        readyO [NumDut];
  logic        stallO [NumDut];
  logic [31:0] dataI  [NumDut];
  logic [31:0] dataO  [NumDut];
`ifdef RAND_STREAM_THROTTLE_STATS_EN
  logic [31:0] xferCnt  [NumDut];
  logic [31:0] stallCnt [NumDut];
`endif

  int numChecks = 0;
  int numFails  = 0;

  int sbPending [NumDut];
  int runIdx = 0;
  int dut2Xfers = 0;
  int gapHits [4];
  int gapsA [NumGapRec];
  int gapsB [NumGapRec];
  int nA = 0;
  int nB = 0;
  logic prevStall3 = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  for (genvar g = 0; g < NumDut; g++) begin : gDut
    logic [31:0] sbQ[$];

    rand_stream_throttle #(
      .DataWidth (32),
      .MinWait   (MinW[g]),
      .MaxWait   (MaxW[g]),
      .Seed      (32'hDEADBEEF)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .en_i       (enI[g]),
      .valid_i    (validI[g]),
      .ready_o    (readyO[g]),
      .data_i     (dataI[g]),
      .valid_o    (validO[g]),
      .ready_i    (readyI[g]),
      .data_o     (dataO[g]),
      .stalling_o (stallO[g])
`ifdef RAND_STREAM_THROTTLE_STATS_EN
      ,
      .xfer_cnt_o  (xferCnt[g]),
      .stall_cnt_o (stallCnt[g])
`endif
    );

    // Scoreboard: accepted upstream beats are queued, downstream beats popped.
    initial sbPending[g] = 0;
    always @(negedge clk) begin
      checkOutput("data_pass", dataO[g], dataI[g]);
      if (validI[g] && readyO[g]) begin
        sbQ.push_back(dataI[g]);
        sbPending[g]++;
      end
      if (validO[g] && readyI[g]) begin
        checkOutput("sb_nonempty", 32'(sbQ.size() != 0), 32'd1);
        if (sbQ.size() != 0) begin
          checkOutput("sb_data", dataO[g], sbQ.pop_front());
          sbPending[g]--;
        end
      end
    end

    if (g != 2) begin : gExact
      int   gapLeft = 0;
      int   mXfer   = 0;
      int   mStall  = 0;
      logic expStall;

      always @(negedge clk) begin
        if (!rst_n) begin
          checkOutput("rst_valid", 32'(validO[g]), 32'(validI[g]));
          checkOutput("rst_ready", 32'(readyO[g]), 32'(readyI[g]));
          checkOutput("rst_stall", 32'(stallO[g]), 32'd0);
`ifdef RAND_STREAM_THROTTLE_STATS_EN
          checkOutput("rst_xfer_cnt", xferCnt[g], 32'd0);
          checkOutput("rst_stall_cnt", stallCnt[g], 32'd0);
`endif
          gapLeft = 0;
          mXfer   = 0;
          mStall  = 0;
        end else begin
          expStall = enI[g] && (gapLeft > 0);
          checkOutput("model_stall", 32'(stallO[g]), 32'(expStall));
          checkOutput("model_valid", 32'(validO[g]), 32'(validI[g] && !expStall));
          checkOutput("model_ready", 32'(readyO[g]), 32'(readyI[g] && !expStall));
`ifdef RAND_STREAM_THROTTLE_STATS_EN
          checkOutput("stat_xfer", xferCnt[g], 32'(mXfer));
          checkOutput("stat_stall", stallCnt[g], 32'(mStall));
`endif
          if (!enI[g]) begin
            gapLeft = 0;
          end else if (gapLeft > 0) begin
            gapLeft--;
            mStall++;
          end else if (validI[g] && readyI[g]) begin
            gapLeft = MinW[g];
            mXfer++;
          end
        end
      end
    end else begin : gRand
      int closed   = 0;
      bit haveLast = 1'b0;

      always @(negedge clk) begin
        if (!rst_n) begin
          checkOutput("rst_valid", 32'(validO[g]), 32'(validI[g]));
          checkOutput("rst_ready", 32'(readyO[g]), 32'(readyI[g]));
          checkOutput("rst_stall", 32'(stallO[g]), 32'd0);
          closed   = 0;
          haveLast = 1'b0;
        end else begin
          checkOutput("gate_valid", 32'(validO[g]), 32'(validI[g] && !stallO[g]));
          checkOutput("gate_ready", 32'(readyO[g]), 32'(readyI[g] && !stallO[g]));
          if (validO[g] && readyI[g]) begin
            if (haveLast) begin
              checkOutput("gap_range", 32'(closed >= MinW[g] && closed <= MaxW[g]), 32'd1);
              if (closed >= MinW[g] && closed <= MaxW[g]) gapHits[closed - MinW[g]]++;
              if (runIdx == 0 && nA < NumGapRec) begin
                gapsA[nA] = closed;
                nA++;
              end else if (runIdx == 1 && nB < NumGapRec) begin
                gapsB[nB] = closed;
                nB++;
              end
            end
            dut2Xfers++;
            haveLast = 1'b1;
            closed   = 0;
          end else if (stallO[g]) begin
            closed++;
          end
        end
      end
    end
  end

  // One cycle of stimulus: new payloads, random traffic on instance 3 and an
  // occasional en_i drop on the first closed cycle of its gap.
  task automatic applyStimulus();
    logic s3;
    logic dropNow;
    @(posedge clk);
    #1;
    dropNow = 1'b0;
    s3 = stallO[3];
    for (int k = 0; k < NumDut; k++) dataI[k] = $urandom;
    validI[3] = ($urandom_range(0, 3) != 0);
    readyI[3] = ($urandom_range(0, 3) != 0);
    if (!enI[3]) begin
      enI[3] = 1'b1;
    end else if (s3 && !prevStall3 && ($urandom_range(0, 3) == 0)) begin
      enI[3]  = 1'b0;
      dropNow = 1'b1;
    end
    prevStall3 = s3;
    #1;
    if (dropNow) begin
      checkOutput("en_drop_valid", 32'(validO[3]), 32'(validI[3]));
      checkOutput("en_drop_stall", 32'(stallO[3]), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    for (int k = 0; k < 4; k++) gapHits[k] = 0;
    rst_n = 1'b0;
    for (int k = 0; k < NumDut; k++) begin
      enI[k]    = 1'b1;
      validI[k] = 1'b1;
      readyI[k] = 1'b1;
      dataI[k]  = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] phase A: steady throttling");
    cyc = 0;
    while (dut2Xfers < TargetXfers && cyc < 60000) begin
      applyStimulus();
      cyc++;
    end
    checkOutput("phaseA_budget", 32'(dut2Xfers >= TargetXfers), 32'd1);

    $display("[TB] phase B: reset in the middle of a gap");
    cyc = 0;
    while (!stallO[2] && cyc < 20) begin
      applyStimulus();
      cyc++;
    end
    checkOutput("wait_for_gap", 32'(stallO[2]), 32'd1);
    #1 rst_n = 1'b0;
    runIdx = 1;
    #1;
    checkOutput("rst_mid_valid", 32'(validO[2]), 32'(validI[2]));
    checkOutput("rst_mid_stall", 32'(stallO[2]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    while (nB < NumGapRec && cyc < 2000) begin
      applyStimulus();
      cyc++;
    end
    checkOutput("phaseB_budget", 32'(nB), 32'(NumGapRec));
    for (int i = 0; i < NumGapRec; i++) checkOutput("gap_repeat", 32'(gapsB[i]), 32'(gapsA[i]));
    for (int k = 0; k < 4; k++) checkOutput("gap_hit", 32'(gapHits[k] > 0), 32'd1);
    for (int k = 0; k < NumDut; k++) checkOutput("sb_drain", 32'(sbPending[k]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule : tb_rand_stream_throttle
